status_panel_renderer: RTL and testbench

STATUS_PANEL_RENDERER -- requirements
Module: status_panel_renderer

---
 rtl/status_panel_renderer.sv | 220 ++++++++++++++++++++++
 tb/tb_status_panel_renderer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/status_panel_renderer.sv
// status_panel_renderer
//   Draws a status panel on top of a VGA raster. The panel has a border, a
//   temperature bar, one lamp per indicator channel and an intrusion box.
//   It also runs a three-state alarm machine (NORMAL / ALARM / ACKED).
//   Sensor inputs are snapshotted at frame start so that a frame never shows
//   a mix of old and new values.
// Ports:
//   clk_100MHz  system clock; all state changes on the rising edge
//   reset       asynchronous, active-high reset
//   p_tick      pixel enable, one clock wide
//   video_on    active-video flag, qualified by p_tick
//   x, y        current pixel coordinates
//   ind_status  2 bits per channel: 00 off, 01 ok, 10 warn, 11 fault
//   temp        temperature reading
//   temp_limit  temperature threshold
//   intrusion   intrusion sensor (level)
//   ack         operator acknowledge pulse
//   rgb         RRRRGGGGBBBB pixel colour, one pixel of latency
//   alarm       high while the alarm machine is in ALARM
module status_panel_renderer #(
    parameter int N_IND        = 8,
    parameter int X0           = 120,
    parameter int Y0           = 110,
    parameter int W            = 400,
    parameter int H            = 260,
    parameter int BORDER       = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               p_tick,
    input  logic               video_on,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic [2*N_IND-1:0] ind_status,
    input  logic [7:0]         temp,
    input  logic [7:0]         temp_limit,
    input  logic               intrusion,
    input  logic               ack,
    output logic [11:0]        rgb,
    output logic               alarm
);
    typedef enum logic [1:0] {NORMAL, ALARM, ACKED} state_t;

    localparam int CNT_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

    // Panel geometry, 11 bits wide so the sums cannot wrap
    localparam logic [10:0] PX_L   = 11'(X0);
    localparam logic [10:0] PX_R   = 11'(X0 + W - 1);
    localparam logic [10:0] PY_T   = 11'(Y0);
    localparam logic [10:0] PY_B   = 11'(Y0 + H - 1);
    localparam logic [10:0] BX_L   = 11'(X0 + BORDER);
    localparam logic [10:0] BX_R   = 11'(X0 + W - 1 - BORDER);
    localparam logic [10:0] BY_T   = 11'(Y0 + BORDER);
    localparam logic [10:0] BY_B   = 11'(Y0 + H - 1 - BORDER);
    localparam logic [10:0] XB     = 11'(X0 + (W - 256) / 2);
    localparam logic [10:0] XB_R   = 11'(X0 + (W - 256) / 2 + 255);
    localparam logic [10:0] BAR_T  = 11'(Y0 + 100);
    localparam logic [10:0] BAR_B  = 11'(Y0 + 115);
    localparam logic [10:0] IND_T  = 11'(Y0 + H - 35);
    localparam logic [10:0] IND_B  = 11'(Y0 + H - 21);
    localparam logic [10:0] BOX_L  = 11'(X0 + W - 80);
    localparam logic [10:0] BOX_R  = 11'(X0 + W - 31);
    localparam logic [10:0] BOX_T  = 11'(Y0 + 40);
    localparam logic [10:0] BOX_B  = 11'(Y0 + 79);

    logic [2*N_IND-1:0] ind_q, ind_d;
    logic [7:0]         temp_q, temp_d;
    logic               intr_q, intr_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               blink_q, blink_d;
    logic               eval_q, eval_d;
    logic [11:0]        rgb_reg_q, rgb_reg_d;
    logic               video_on_d_q, video_on_d_d;
    state_t             state_q;
    logic               alarm_q;

    logic        fs;
    logic        cond;
    logic        any_fault;
    logic [10:0] xe, ye, off;
    logic        ind_hit;
    logic [1:0]  ind_code;
    logic [11:0] border_col;
    logic [11:0] pix;

    assign fs = p_tick && (x == 10'd0) && (y == 10'd0);

    // Frame-start snapshot and blink timing
    always_comb begin
        ind_d       = ind_q;
        temp_d      = temp_q;
        intr_d      = intr_q;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        eval_d      = fs;
        if (fs) begin
            ind_d  = ind_status;
            temp_d = temp;
            intr_d = intrusion;
            if (frame_cnt_q == CNT_MAX) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        any_fault = 1'b0;
        for (int unsigned i = 0; i < N_IND; i++) begin
            if (ind_q[2*i +: 2] == 2'b11) any_fault = 1'b1;
        end
        cond = (temp_q > temp_limit) || intr_q || any_fault;
    end

    // Pixel colour, first matching region wins
    always_comb begin
        xe       = {1'b0, x};
        ye       = {1'b0, y};
        off      = xe - XB;
        ind_hit  = 1'b0;
        ind_code = 2'b00;
        for (int unsigned i = 0; i < N_IND; i++) begin
            if (xe >= 11'(X0 + 20 + 40 * i) && xe <= 11'(X0 + 49 + 40 * i)) begin
                ind_hit  = 1'b1;
                ind_code = ind_q[2*i +: 2];
            end
        end

        case (state_q)
            ALARM:   border_col = blink_q ? 12'hF00 : 12'h0F0;
            ACKED:   border_col = 12'hF00;
            default: border_col = 12'h0F0;
        endcase

        if (xe < PX_L || xe > PX_R || ye < PY_T || ye > PY_B) begin
            pix = 12'h000;
        end else if (xe < BX_L || xe > BX_R || ye < BY_T || ye > BY_B) begin
            pix = border_col;
        end else if (ye >= BAR_T && ye <= BAR_B && xe >= XB && xe <= XB_R) begin
            if (off == {3'b000, temp_limit})
                pix = 12'hFFF;
            else if (off < {3'b000, temp_q})
                pix = (temp_q > temp_limit) ? 12'hF00 : 12'h0F0;
            else
                pix = 12'h000;
        end else if (ye >= IND_T && ye <= IND_B && ind_hit) begin
            case (ind_code)
                2'b00:   pix = 12'h444;
                2'b01:   pix = 12'h0F0;
                2'b10:   pix = 12'hF80;
                default: pix = blink_q ? 12'hF00 : 12'h000;
            endcase
        end else if (ye >= BOX_T && ye <= BOX_B && xe >= BOX_L && xe <= BOX_R) begin
            pix = intr_q ? 12'hF00 : 12'h000;
        end else begin
            pix = 12'hFF0;
        end

        rgb_reg_d    = p_tick ? pix : rgb_reg_q;
        video_on_d_d = p_tick ? video_on : video_on_d_q;
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            ind_q        <= '0;
            temp_q       <= '0;
            intr_q       <= 1'b0;
            frame_cnt_q  <= '0;
            blink_q      <= 1'b0;
            eval_q       <= 1'b0;
            rgb_reg_q    <= '0;
            video_on_d_q <= 1'b0;
        end else begin
            ind_q        <= ind_d;
            temp_q       <= temp_d;
            intr_q       <= intr_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_q      <= blink_d;
            eval_q       <= eval_d;
            rgb_reg_q    <= rgb_reg_d;
            video_on_d_q <= video_on_d_d;
        end
    end

    // Alarm machine; evaluation happens the cycle after frame start so the
    // snapshot is already in place. ack in ALARM wins over evaluation.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= NORMAL;
            alarm_q <= 1'b0;
        end else begin
            case (state_q)
                NORMAL: if (eval_q && cond) begin
                    state_q <= ALARM;
                    alarm_q <= 1'b1;
                end
                ALARM: if (ack) begin
                    state_q <= ACKED;
                    alarm_q <= 1'b0;
                end
                ACKED: if (eval_q && !cond) begin
                    state_q <= NORMAL;
                    alarm_q <= 1'b0;
                end
                default: begin
                    state_q <= NORMAL;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

    assign rgb   = video_on_d_q ? rgb_reg_q : 12'h000;
    assign alarm = alarm_q;

endmodule

// File: tb/tb_status_panel_renderer.sv
// Testbench for status_panel_renderer with default parameters.
// Geometry: panel x 120..519, y 110..369, border 3; bar x 192..447, y 210..225;
// indicators y 335..349, channel i x 140+40i..169+40i; intrusion box
// x 440..489, y 150..189.
module tb_status_panel_renderer;
    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        video_on;
    logic [9:0]  x, y;
    logic [15:0] ind_status;
    logic [7:0]  temp, temp_limit;
    logic        intrusion;
    logic        ack;
    logic [11:0] rgb;
    logic        alarm;

    always #5 clk_100MHz = ~clk_100MHz;

    status_panel_renderer #(
        .N_IND(8), .X0(120), .Y0(110), .W(400), .H(260), .BORDER(3), .BLINK_FRAMES(30)
    ) dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .x(x), .y(y), .ind_status(ind_status), .temp(temp), .temp_limit(temp_limit),
        .intrusion(intrusion), .ack(ack), .rgb(rgb), .alarm(alarm)
    );

    localparam int XB = 192;
    localparam int BY = 215;
    localparam int IY = 340;

    typedef struct {
        logic [11:0] rgb;
        logic        alarm;
        bit          chk_alarm;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   fs_n     = 0;   // frame starts since reset
    int   st       = 0;   // expected state: 0 NORMAL, 1 ALARM, 2 ACKED
    logic exp_alarm = 1'b0;

    function automatic bit blink();
        return ((fs_n / 30) % 2) == 1;
    endfunction

    function automatic logic [11:0] border_exp();
        case (st)
            1:       return blink() ? 12'hF00 : 12'h0F0;
            2:       return 12'hF00;
            default: return 12'h0F0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic probe(input int px, input int py, input logic [11:0] e,
                         input string tag, input logic von = 1'b1);
        @(negedge clk_100MHz);
        x = px[9:0]; y = py[9:0]; video_on = von; p_tick = 1'b1;
        sb.push_back('{e, exp_alarm, 1'b1, tag});
        @(negedge clk_100MHz);
        p_tick = 1'b0; video_on = 1'b0;
    endtask

    task automatic frame(input bit ack_eval = 1'b0);
        @(negedge clk_100MHz);
        x = '0; y = '0; video_on = 1'b0; p_tick = 1'b1;
        sb.push_back('{12'h000, 1'b0, 1'b0, "fs"});
        fs_n++;
        @(negedge clk_100MHz);
        p_tick = 1'b0; ack = ack_eval;
        @(negedge clk_100MHz);
        ack = 1'b0;
        repeat (2) @(negedge clk_100MHz);
    endtask

    // Monitor: every pixel tick produces one output pixel a cycle later
    initial begin
        bit   take;
        exp_t e;
        forever begin
            @(posedge clk_100MHz);
            take = (p_tick === 1'b1);
            @(negedge clk_100MHz);
            if (take) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow got=%h exp=none", rgb);
                end else begin
                    e = sb.pop_front();
                    if (rgb !== e.rgb) begin
                        failures++;
                        $display("FAIL %s_rgb got=%h exp=%h", e.tag, rgb, e.rgb);
                    end
                    if (e.chk_alarm) begin
                        checks++;
                        if (alarm !== e.alarm) begin
                            failures++;
                            $display("FAIL %s_alarm got=%b exp=%b", e.tag, alarm, e.alarm);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; x = '0; y = '0;
        ind_status = '0; temp = '0; temp_limit = 8'd100; intrusion = 1'b0; ack = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        check("reset_alarm", {11'b0, alarm}, 12'h000);
        check("reset_rgb", rgb, 12'h000);
        reset = 1'b0;

        // Normal operation, temp below limit
        temp = 8'd50; ind_status = 16'h5555;
        frame(); st = 0; exp_alarm = 1'b0;
        probe(XB + 10,  BY, 12'h0F0, "bar_fill");
        probe(XB + 100, BY, 12'hFFF, "bar_limit");
        probe(XB + 60,  BY, 12'h000, "bar_empty");
        probe(XB + 49,  BY, 12'h0F0, "bar_last_fill");
        probe(XB + 50,  BY, 12'h000, "bar_first_empty");
        probe(120, 200, 12'h0F0, "border_left");
        probe(519, 200, 12'h0F0, "border_right");
        probe(123, 200, 12'hFF0, "bg_inside");
        probe(520, 200, 12'h000, "outside_right");
        probe(300, 369, 12'h0F0, "border_bottom");
        probe(300, 370, 12'h000, "outside_below");
        probe(140, IY, 12'h0F0, "ind0_ok");
        probe(449, IY, 12'h0F0, "ind7_ok");
        probe(450, IY, 12'hFF0, "ind_gap_right");
        probe(139, IY, 12'hFF0, "ind_gap_left");
        probe(460, 170, 12'h000, "box_clear");
        probe(XB + 10, BY, 12'h000, "blanked", 1'b0);

        // Mid-frame change must not show until next frame start
        temp = 8'd120;
        probe(XB + 10,  BY, 12'h0F0, "tear_fill");
        probe(XB + 110, BY, 12'h000, "tear_empty");
        frame(); st = 1; exp_alarm = 1'b1;
        probe(XB + 10,  BY, 12'hF00, "hot_fill");
        probe(XB + 110, BY, 12'hF00, "hot_fill2");
        probe(XB + 100, BY, 12'hFFF, "hot_limit");
        probe(XB + 120, BY, 12'h000, "hot_end");
        probe(120, 200, border_exp(), "alarm_border");
        while (fs_n < 62) begin
            frame();
            probe(120, 200, border_exp(), "blink_border");
        end

        // Acknowledge, then cool down
        @(negedge clk_100MHz); ack = 1'b1;
        @(negedge clk_100MHz); ack = 1'b0;
        st = 2; exp_alarm = 1'b0;
        probe(120, 200, 12'hF00, "acked_border");
        frame();
        probe(120, 200, 12'hF00, "acked_hold");
        temp = 8'd90;
        frame(); st = 0;
        probe(120, 200, 12'h0F0, "back_normal");
        probe(XB + 10, BY, 12'h0F0, "cool_fill");

        // Condition clears without ack: alarm persists
        temp = 8'd120;
        frame(); st = 1; exp_alarm = 1'b1;
        probe(120, 200, border_exp(), "realarm");
        temp = 8'd90;
        for (int k = 0; k < 3; k++) begin
            frame();
            probe(120, 200, border_exp(), "persist");
        end
        probe(XB + 10, BY, 12'h0F0, "persist_bar");

        // ack coincident with evaluation in ALARM
        temp = 8'd120;
        frame(1'b1); st = 2; exp_alarm = 1'b0;
        probe(120, 200, 12'hF00, "ack_at_eval");
        temp = 8'd90;
        frame(); st = 0;
        probe(120, 200, 12'h0F0, "normal_again");
        // ack in NORMAL is ignored
        temp = 8'd120;
        frame(1'b1); st = 1; exp_alarm = 1'b1;
        probe(120, 200, border_exp(), "ack_ignored");

        // Indicators: ch0 warn, ch1 ok, ch2 fault, rest ok
        temp = 8'd50; ind_status = 16'h5576;
        for (int k = 0; k < 31; k++) begin
            frame();
            probe(230, IY, blink() ? 12'hF00 : 12'h000, "ind2_fault");
            probe(150, IY, 12'hF80, "ind0_warn");
        end
        probe(190, IY, 12'h0F0, "ind1_ok");

        // Intrusion box
        intrusion = 1'b1;
        frame();
        probe(460, 170, 12'hF00, "box_alarm");
        probe(489, 189, 12'hF00, "box_corner");
        probe(490, 170, 12'hFF0, "box_right_out");
        probe(439, 170, 12'hFF0, "box_left_out");

        // Asynchronous reset while in ALARM
        @(negedge clk_100MHz);
        x = 10'd300; y = 10'd200;
        #2 reset = 1'b1;
        #1;
        check("rst_alarm", {11'b0, alarm}, 12'h000);
        check("rst_rgb", rgb, 12'h000);
        @(posedge clk_100MHz); #1;
        check("rst_frame_cnt", 12'(dut.frame_cnt_q), 12'h000);
        @(negedge clk_100MHz);
        reset = 1'b0;
        fs_n = 0; st = 0; exp_alarm = 1'b0;
        probe(XB + 10,  BY, 12'h000, "post_rst_bar");
        probe(XB + 100, BY, 12'hFFF, "post_rst_limit");
        probe(150, IY, 12'h444, "post_rst_ind");
        probe(460, 170, 12'h000, "post_rst_box");
        probe(120, 200, 12'h0F0, "post_rst_border");

        repeat (5) @(negedge clk_100MHz);
        check("sb_drained", 12'(sb.size()), 12'h000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
